decode_stage_pipe: RTL and testbench
====================================

// Module: decode_stage_pipe
// PURPOSE
// Parametrised decode stage: owns the architectural register file, reads two operands, and registers them
// into the ID/EX pipeline register. Extends the plain decode stage with write-through bypass, load-use
// hazard detection with bubble insertion, stall/flush control and a saturating bubble counter.
// Sits between fetch/IF-ID latch and the execute stage; write-back port is driven by the WB stage.
// PARAMETERS
// DATA_W    16  operand/register width in bits
// REG_CNT    8  number of architectural registers (power of two, >=2)
// ADDR_W     3  register address width, must equal $clog2(REG_CNT)
// CNT_W      8  width of the bubble counter
// PORTS
// clk            in   1       rising-edge clock
// reset          in   1       synchronous, active-high reset
// in_valid       in   1       IF/ID holds a valid instruction
// src_addr       in   ADDR_W  source register address
// dst_addr       in   ADDR_W  destination register address (also read as operand 2)
// write_back     in   1       WB write enable
// write_addr     in   ADDR_W  WB destination address
// write_data     in   DATA_W  WB data
// ex_valid       in   1       instruction currently in EX is valid
// ex_mem_read    in   1       instruction in EX is a load
// ex_dst_addr    in   ADDR_W  destination of instruction in EX
// stall          in   1       downstream stall: hold ID/EX register
// flush          in   1       squash: invalidate ID/EX register
// read_data1     out  DATA_W  registered operand 1 (src)
// alu_input2     out  DATA_W  registered operand 2 (dst)
// out_src_addr   out  ADDR_W  registered src address
// out_dst_addr   out  ADDR_W  registered dst address
// out_valid      out  1       ID/EX contents valid
// hazard_stall   out  1       combinational: load-use hazard, IF/ID must hold
// bubble_count   out  CNT_W   bubbles inserted since reset, saturating
// BEHAVIOUR
// - Reset (sync, highest priority): all REG_CNT registers <= 0; all outputs <= 0; out_valid <= 0.
// - RF write: at posedge, if write_back, reg[write_addr] <= write_data. Register 0 is writable.
// - RF read: combinational; if write_back && write_addr == addr, return write_data (same-cycle bypass).
// - hazard_stall = in_valid & ex_valid & ex_mem_read & (ex_dst_addr==src_addr | ex_dst_addr==dst_addr).
// - ID/EX update priority per posedge: reset > flush > stall > hazard_stall > load.
//   flush: out_valid<=0, data fields hold. stall: all fields hold (hazard ignored while stalled).
//   hazard_stall: out_valid<=0 (bubble), bubble_count += 1 unless at all-ones.
//   load: capture operands/addresses, out_valid<=in_valid.
// - Latency: operand read in cycle N appears on outputs after posedge N (1 cycle).
// - flush and stall together: flush wins, no bubble counted.
// - bubble_count saturates at 2^CNT_W-1; never wraps.
// - WB write in the same cycle as a held (stall) ID/EX does NOT update held operands; EX forwarding covers it.
// - Reset mid-hazard: hazard_stall still evaluates combinationally, but ID/EX and counter take reset values.
// STRUCTURE
// - decode_pkg: DATA_W/REG_CNT/ADDR_W defaults, ADDR_W derivation, idex_t struct {data1,data2,src,dst,valid}.
// - Sub-module reg_file_bypass (REG_CNT x DATA_W, 1 write, 2 read ports, write-through, sync reset).
// - Top holds hazard logic, ID/EX register and bubble counter.
// TESTING
// - Reset held 2 cycles -> all outputs 0, reads of R0..R7 return 0 after release.
// - write_back=1 R3<=16'hBEEF while src_addr=3 same cycle -> read_data1=16'hBEEF next cycle.
// - ex_mem_read=1, ex_valid=1, ex_dst_addr=2, dst_addr=2, in_valid=1 -> hazard_stall=1, out_valid=0 next, bubble_count=1.
// - stall=1 for 3 cycles with changing inputs -> outputs frozen; stall+flush together -> out_valid=0, count unchanged.
// - CNT_W=2, force 5 hazard cycles -> bubble_count sticks at 3.
// - Parameter sweep DATA_W=32, REG_CNT=16: write/read all 16 regs with distinct patterns -> exact match.

Source files
------------

// File: rtl/decode_stage_pipe_pkg.sv
// Decode stage package: default geometry, address-width helper and the
// default-width layout of the ID/EX pipeline register.
package decode_stage_pipe_pkg;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_REG_CNT = 8;
  localparam int DEF_CNT_W   = 8;

  // Register address width for a given register count (at least 1 bit).
  function automatic int addrWidth(input int regCnt);
    return (regCnt > 1) ? $clog2(regCnt) : 1;
  endfunction

  localparam int DEF_ADDR_W = addrWidth(DEF_REG_CNT);

  // ID/EX register contents at the default widths.
  typedef struct packed {
    logic [DEF_DATA_W-1:0] data1;
    logic [DEF_DATA_W-1:0] data2;
    logic [DEF_ADDR_W-1:0] src;
    logic [DEF_ADDR_W-1:0] dst;
    logic                  valid;
  } idex_t;

endpackage

// File: rtl/decode_stage_pipe_if.sv
// Decode stage bus: IF/ID request, WB write port, EX hazard info,
// pipeline control and the registered ID/EX outputs.
interface decode_stage_pipe_if #(
  parameter int DATA_W = decode_stage_pipe_pkg::DEF_DATA_W,
  parameter int ADDR_W = decode_stage_pipe_pkg::DEF_ADDR_W,
  parameter int CNT_W  = decode_stage_pipe_pkg::DEF_CNT_W
);
  import decode_stage_pipe_pkg::*;

  logic              in_valid;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic              write_back;
  logic [ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0] write_data;
  logic              ex_valid;
  logic              ex_mem_read;
  logic [ADDR_W-1:0] ex_dst_addr;
  logic              stall;
  logic              flush;
  logic [DATA_W-1:0] read_data1;
  logic [DATA_W-1:0] alu_input2;
  logic [ADDR_W-1:0] out_src_addr;
  logic [ADDR_W-1:0] out_dst_addr;
  logic              out_valid;
  logic              hazard_stall;
  logic [CNT_W-1:0]  bubble_count;

  modport master (
    output in_valid, src_addr, dst_addr, write_back, write_addr, write_data,
           ex_valid, ex_mem_read, ex_dst_addr, stall, flush,
    input  read_data1, alu_input2, out_src_addr, out_dst_addr, out_valid,
           hazard_stall, bubble_count
  );

  modport slave (
    input  in_valid, src_addr, dst_addr, write_back, write_addr, write_data,
           ex_valid, ex_mem_read, ex_dst_addr, stall, flush,
    output read_data1, alu_input2, out_src_addr, out_dst_addr, out_valid,
           hazard_stall, bubble_count
  );

endinterface

// File: rtl/decode_stage_pipe_reg_file_bypass.sv
// Architectural register file: one write port, two combinational read
// ports with same-cycle write-through, synchronous clear on reset.
module reg_file_bypass #(
  parameter int DATA_W  = decode_stage_pipe_pkg::DEF_DATA_W,
  parameter int REG_CNT = decode_stage_pipe_pkg::DEF_REG_CNT,
  parameter int ADDR_W  = decode_stage_pipe_pkg::DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o
);
  import decode_stage_pipe_pkg::*;

  logic [DATA_W-1:0] regs_q [REG_CNT];

  // Clear every register on reset, otherwise commit the WB write (R0 included).
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_CNT; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (we_i && (waddr_i == raddr1_i)) ? wdata_i : regs_q[raddr1_i];
  assign rdata2_o = (we_i && (waddr_i == raddr2_i)) ? wdata_i : regs_q[raddr2_i];

endmodule

// File: rtl/decode_stage_pipe.sv
// Decode stage: reads two operands from the register file, detects
// load-use hazards, and registers the result into ID/EX with
// flush/stall/bubble control and a saturating bubble counter.
module decode_stage_pipe #(
  parameter int DATA_W  = decode_stage_pipe_pkg::DEF_DATA_W,
  parameter int REG_CNT = decode_stage_pipe_pkg::DEF_REG_CNT,
  parameter int ADDR_W  = decode_stage_pipe_pkg::addrWidth(REG_CNT),
  parameter int CNT_W   = decode_stage_pipe_pkg::DEF_CNT_W
) (
  input  logic                clk,
  input  logic                reset,
  decode_stage_pipe_if.slave  bus
);
  import decode_stage_pipe_pkg::*;

  typedef struct packed {
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic              valid;
  } idexReg_t;

  logic [DATA_W-1:0] rfData1;
  logic [DATA_W-1:0] rfData2;
  logic              hazard;
  idexReg_t          idex_q;
  idexReg_t          idex_d;
  logic [CNT_W-1:0]  bubbleCnt_q;
  logic [CNT_W-1:0]  bubbleCnt_d;

  reg_file_bypass #(
    .DATA_W  (DATA_W),
    .REG_CNT (REG_CNT),
    .ADDR_W  (ADDR_W)
  ) uRegFile (
    .clk      (clk),
    .reset    (reset),
    .we_i     (bus.write_back),
    .waddr_i  (bus.write_addr),
    .wdata_i  (bus.write_data),
    .raddr1_i (bus.src_addr),
    .raddr2_i (bus.dst_addr),
    .rdata1_o (rfData1),
    .rdata2_o (rfData2)
  );

  assign hazard = bus.in_valid & bus.ex_valid & bus.ex_mem_read &
                  ((bus.ex_dst_addr == bus.src_addr) | (bus.ex_dst_addr == bus.dst_addr));

  // Next ID/EX contents: flush squashes, stall holds, hazard bubbles, else load.
  always_comb begin
    idex_d      = idex_q;
    bubbleCnt_d = bubbleCnt_q;
    if (bus.flush) begin
      idex_d.valid = 1'b0;
    end else if (!bus.stall) begin
      if (hazard) begin
        idex_d.valid = 1'b0;
        if (bubbleCnt_q != {CNT_W{1'b1}}) begin
          bubbleCnt_d = bubbleCnt_q + CNT_W'(1);
        end
      end else begin
        idex_d.data1 = rfData1;
        idex_d.data2 = rfData2;
        idex_d.src   = bus.src_addr;
        idex_d.dst   = bus.dst_addr;
        idex_d.valid = bus.in_valid;
      end
    end
  end

  // Register ID/EX and the bubble counter; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      idex_q      <= '0;
      bubbleCnt_q <= '0;
    end else begin
      idex_q      <= idex_d;
      bubbleCnt_q <= bubbleCnt_d;
    end
  end

  assign bus.read_data1   = idex_q.data1;
  assign bus.alu_input2   = idex_q.data2;
  assign bus.out_src_addr = idex_q.src;
  assign bus.out_dst_addr = idex_q.dst;
  assign bus.out_valid    = idex_q.valid;
  assign bus.hazard_stall = hazard;
  assign bus.bubble_count = bubbleCnt_q;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed bench for decode_stage_pipe: a table of hand-computed vectors on
// the default configuration plus sequences for reset, counter saturation
// (CNT_W=2) and a 32-bit/16-register sweep.
module tb_decode_stage_pipe;
  import decode_stage_pipe_pkg::*;

  logic clk = 1'b0;
  logic reset;

  int vecCount = 0;
  int errCount = 0;

  always #5 clk = ~clk;

  decode_stage_pipe_if #(.DATA_W(16), .ADDR_W(3), .CNT_W(8)) busA ();
  decode_stage_pipe_if #(.DATA_W(16), .ADDR_W(3), .CNT_W(2)) busB ();
  decode_stage_pipe_if #(.DATA_W(32), .ADDR_W(4), .CNT_W(8)) busC ();

  decode_stage_pipe #(.DATA_W(16), .REG_CNT(8), .ADDR_W(3), .CNT_W(8)) dutA (
    .clk(clk), .reset(reset), .bus(busA)
  );
  decode_stage_pipe #(.DATA_W(16), .REG_CNT(8), .ADDR_W(3), .CNT_W(2)) dutB (
    .clk(clk), .reset(reset), .bus(busB)
  );
  decode_stage_pipe #(.DATA_W(32), .REG_CNT(16), .ADDR_W(4), .CNT_W(8)) dutC (
    .clk(clk), .reset(reset), .bus(busC)
  );

  typedef struct {
    logic        inValid;
    logic [2:0]  src;
    logic [2:0]  dst;
    logic        wb;
    logic [2:0]  wAddr;
    logic [15:0] wData;
    logic        exValid;
    logic        exMemRead;
    logic [2:0]  exDst;
    logic        stall;
    logic        flush;
    logic        expHazard;
    idex_t       expIdex;
    logic [7:0]  expBubbles;
  } vec_t;

  vec_t vecs [18];

  function automatic vec_t mkVec(
    input logic inValid, input logic [2:0] src, input logic [2:0] dst,
    input logic wb, input logic [2:0] wAddr, input logic [15:0] wData,
    input logic exValid, input logic exMemRead, input logic [2:0] exDst,
    input logic stall, input logic flush,
    input logic expHazard, input logic [15:0] d1, input logic [15:0] d2,
    input logic [2:0] eSrc, input logic [2:0] eDst, input logic eValid,
    input logic [7:0] eBub);
    vec_t v;
    v.inValid = inValid; v.src = src; v.dst = dst;
    v.wb = wb; v.wAddr = wAddr; v.wData = wData;
    v.exValid = exValid; v.exMemRead = exMemRead; v.exDst = exDst;
    v.stall = stall; v.flush = flush;
    v.expHazard = expHazard;
    v.expIdex.data1 = d1; v.expIdex.data2 = d2;
    v.expIdex.src = eSrc; v.expIdex.dst = eDst; v.expIdex.valid = eValid;
    v.expBubbles = eBub;
    return v;
  endfunction

  function automatic logic [31:0] patC(input int i);
    return (32'h1000_0001 * (i + 1)) ^ 32'hA5A5_0000;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clearInputs();
    busA.in_valid = 0; busA.src_addr = 0; busA.dst_addr = 0; busA.write_back = 0;
    busA.write_addr = 0; busA.write_data = 0; busA.ex_valid = 0; busA.ex_mem_read = 0;
    busA.ex_dst_addr = 0; busA.stall = 0; busA.flush = 0;
    busB.in_valid = 0; busB.src_addr = 0; busB.dst_addr = 0; busB.write_back = 0;
    busB.write_addr = 0; busB.write_data = 0; busB.ex_valid = 0; busB.ex_mem_read = 0;
    busB.ex_dst_addr = 0; busB.stall = 0; busB.flush = 0;
    busC.in_valid = 0; busC.src_addr = 0; busC.dst_addr = 0; busC.write_back = 0;
    busC.write_addr = 0; busC.write_data = 0; busC.ex_valid = 0; busC.ex_mem_read = 0;
    busC.ex_dst_addr = 0; busC.stall = 0; busC.flush = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    busA.in_valid = v.inValid; busA.src_addr = v.src; busA.dst_addr = v.dst;
    busA.write_back = v.wb; busA.write_addr = v.wAddr; busA.write_data = v.wData;
    busA.ex_valid = v.exValid; busA.ex_mem_read = v.exMemRead; busA.ex_dst_addr = v.exDst;
    busA.stall = v.stall; busA.flush = v.flush;
    #1;
    checkOutput($sformatf("v%0d.hazard", idx), 64'(busA.hazard_stall), 64'(v.expHazard));
    tick();
    checkOutput($sformatf("v%0d.data1", idx), 64'(busA.read_data1), 64'(v.expIdex.data1));
    checkOutput($sformatf("v%0d.data2", idx), 64'(busA.alu_input2), 64'(v.expIdex.data2));
    checkOutput($sformatf("v%0d.src", idx), 64'(busA.out_src_addr), 64'(v.expIdex.src));
    checkOutput($sformatf("v%0d.dst", idx), 64'(busA.out_dst_addr), 64'(v.expIdex.dst));
    checkOutput($sformatf("v%0d.valid", idx), 64'(busA.out_valid), 64'(v.expIdex.valid));
    checkOutput($sformatf("v%0d.bubbles", idx), 64'(busA.bubble_count), 64'(v.expBubbles));
  endtask

  initial begin
    //                inV src dst wb wA  wData     exV exMR exD st fl | haz d1        d2        s  d  v  bub
    vecs[0]  = mkVec(1, 3, 1, 1, 3, 16'hBEEF, 0, 0, 0, 0, 0, 0, 16'hBEEF, 16'h0000, 3, 1, 1, 0);
    vecs[1]  = mkVec(1, 3, 1, 1, 1, 16'h1234, 0, 0, 0, 0, 0, 0, 16'hBEEF, 16'h1234, 3, 1, 1, 0);
    vecs[2]  = mkVec(0, 0, 3, 1, 0, 16'h0A0A, 0, 0, 0, 0, 0, 0, 16'h0A0A, 16'hBEEF, 0, 3, 0, 0);
    vecs[3]  = mkVec(1, 0, 2, 0, 0, 16'h0000, 1, 1, 2, 0, 0, 1, 16'h0A0A, 16'hBEEF, 0, 3, 0, 1);
    vecs[4]  = mkVec(1, 3, 1, 0, 0, 16'h0000, 1, 1, 3, 0, 0, 1, 16'h0A0A, 16'hBEEF, 0, 3, 0, 2);
    vecs[5]  = mkVec(1, 3, 1, 0, 0, 16'h0000, 1, 0, 3, 0, 0, 0, 16'hBEEF, 16'h1234, 3, 1, 1, 2);
    vecs[6]  = mkVec(1, 1, 0, 0, 0, 16'h0000, 0, 1, 1, 0, 0, 0, 16'h1234, 16'h0A0A, 1, 0, 1, 2);
    vecs[7]  = mkVec(0, 2, 2, 0, 0, 16'h0000, 1, 1, 2, 0, 0, 0, 16'h0000, 16'h0000, 2, 2, 0, 2);
    vecs[8]  = mkVec(1, 3, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 16'hBEEF, 16'h0A0A, 3, 0, 1, 2);
    vecs[9]  = mkVec(1, 1, 1, 0, 0, 16'h0000, 0, 0, 0, 0, 1, 0, 16'hBEEF, 16'h0A0A, 3, 0, 0, 2);
    vecs[10] = mkVec(1, 1, 2, 0, 0, 16'h0000, 1, 1, 1, 0, 1, 1, 16'hBEEF, 16'h0A0A, 3, 0, 0, 2);
    vecs[11] = mkVec(1, 1, 2, 0, 0, 16'h0000, 1, 1, 1, 1, 0, 1, 16'hBEEF, 16'h0A0A, 3, 0, 0, 2);
    vecs[12] = mkVec(1, 1, 3, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h1234, 16'hBEEF, 1, 3, 1, 2);
    vecs[13] = mkVec(1, 0, 0, 1, 1, 16'h5555, 0, 0, 0, 1, 0, 0, 16'h1234, 16'hBEEF, 1, 3, 1, 2);
    vecs[14] = mkVec(1, 3, 1, 0, 0, 16'h0000, 0, 0, 0, 1, 0, 0, 16'h1234, 16'hBEEF, 1, 3, 1, 2);
    vecs[15] = mkVec(1, 2, 2, 0, 0, 16'h0000, 1, 1, 2, 1, 0, 1, 16'h1234, 16'hBEEF, 1, 3, 1, 2);
    vecs[16] = mkVec(1, 4, 5, 0, 0, 16'h0000, 1, 1, 4, 1, 1, 1, 16'h1234, 16'hBEEF, 1, 3, 0, 2);
    vecs[17] = mkVec(1, 1, 1, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h5555, 16'h5555, 1, 1, 1, 2);

    // Reset held for two cycles: everything reads back as zero.
    clearInputs();
    reset = 1'b1;
    tick();
    tick();
    checkOutput("rst.data1", 64'(busA.read_data1), 64'h0);
    checkOutput("rst.data2", 64'(busA.alu_input2), 64'h0);
    checkOutput("rst.src", 64'(busA.out_src_addr), 64'h0);
    checkOutput("rst.dst", 64'(busA.out_dst_addr), 64'h0);
    checkOutput("rst.valid", 64'(busA.out_valid), 64'h0);
    checkOutput("rst.bubbles", 64'(busA.bubble_count), 64'h0);
    checkOutput("rst.bubblesB", 64'(busB.bubble_count), 64'h0);
    checkOutput("rst.validC", 64'(busC.out_valid), 64'h0);
    reset = 1'b0;

    // Every register reads zero after reset.
    for (int r = 0; r < 8; r++) begin
      busA.in_valid = 1'b1;
      busA.src_addr = 3'(r);
      busA.dst_addr = 3'(r);
      tick();
      checkOutput($sformatf("rd0.R%0d.data1", r), 64'(busA.read_data1), 64'h0);
      checkOutput($sformatf("rd0.R%0d.data2", r), 64'(busA.alu_input2), 64'h0);
      checkOutput($sformatf("rd0.R%0d.valid", r), 64'(busA.out_valid), 64'h1);
    end

    // Directed table on the default configuration.
    for (int i = 0; i < 18; i++) begin
      applyStimulus(i, vecs[i]);
    end

    // Reset during a hazard: hazard still flags, registered state clears.
    busA.in_valid = 1'b1; busA.src_addr = 3'd3; busA.dst_addr = 3'd1;
    busA.ex_valid = 1'b1; busA.ex_mem_read = 1'b1; busA.ex_dst_addr = 3'd3;
    busA.stall = 1'b0; busA.flush = 1'b0; busA.write_back = 1'b0;
    reset = 1'b1;
    #1;
    checkOutput("rstHaz.hazard", 64'(busA.hazard_stall), 64'h1);
    tick();
    checkOutput("rstHaz.valid", 64'(busA.out_valid), 64'h0);
    checkOutput("rstHaz.bubbles", 64'(busA.bubble_count), 64'h0);
    checkOutput("rstHaz.data1", 64'(busA.read_data1), 64'h0);
    reset = 1'b0;
    busA.ex_valid = 1'b0;
    tick();
    checkOutput("rstHaz.rfR3", 64'(busA.read_data1), 64'h0);
    checkOutput("rstHaz.rfR1", 64'(busA.alu_input2), 64'h0);
    checkOutput("rstHaz.validAfter", 64'(busA.out_valid), 64'h1);

    // CNT_W=2: five hazard cycles saturate the counter at 3.
    busB.in_valid = 1'b1; busB.src_addr = 3'd5; busB.dst_addr = 3'd6;
    busB.ex_valid = 1'b1; busB.ex_mem_read = 1'b1; busB.ex_dst_addr = 3'd6;
    for (int k = 0; k < 5; k++) begin
      tick();
      checkOutput($sformatf("sat.cycle%0d", k), 64'(busB.bubble_count),
                  64'((k + 1 > 3) ? 3 : k + 1));
    end
    busB.ex_valid = 1'b0;
    tick();
    checkOutput("sat.hold", 64'(busB.bubble_count), 64'h3);
    checkOutput("sat.validAfter", 64'(busB.out_valid), 64'h1);

    // 32-bit / 16-register sweep: write distinct patterns, read them back.
    for (int r = 0; r < 16; r++) begin
      busC.write_back = 1'b1;
      busC.write_addr = 4'(r);
      busC.write_data = patC(r);
      tick();
    end
    busC.write_back = 1'b0;
    for (int r = 0; r < 16; r++) begin
      busC.in_valid = 1'b1;
      busC.src_addr = 4'(r);
      busC.dst_addr = 4'(15 - r);
      tick();
      checkOutput($sformatf("sweep.R%0d.data1", r), 64'(busC.read_data1), 64'(patC(r)));
      checkOutput($sformatf("sweep.R%0d.data2", r), 64'(busC.alu_input2), 64'(patC(15 - r)));
      checkOutput($sformatf("sweep.R%0d.valid", r), 64'(busC.out_valid), 64'h1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
